// File: rtl/spi_counter_rx_if.sv
//------------------------------------------------------------------------------
// Module      : spi_counter_rx_if
// Description : Four-wire SPI bus between the counter SPI master and the
//               spi_counter_rx slave receiver.
//               sclk : SPI clock, idle low (master -> slave)
//               mosi : serial data, master -> slave
//               ss   : slave select, active low (master -> slave)
//               miso : serial data, slave -> master
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_counter_rx_if;
    logic sclk;
    logic mosi;
    logic ss;
    logic miso;

    modport master (
        output sclk,
        output mosi,
        output ss,
        input  miso
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  ss,
        output miso
    );
endinterface

`default_nettype wire

// File: rtl/spi_counter_rx.sv
//------------------------------------------------------------------------------
// Module      : spi_counter_rx
// Description : SPI mode-0 slave that reassembles the two-byte counter frame
//               {2'b00, cnt[13:8]}, cnt[7:0] (MSB first) into a 14-bit value.
//               Malformed or partial frames are flagged and discarded; the
//               previously received value is shifted back on MISO.
//               All SPI inputs are asynchronous and oversampled by clk.
// Ports       : clk         - system clock
//               reset       - synchronous, active-high reset
//               spi         - SPI bus (slave modport: sclk, mosi, ss, miso)
//               o_counter   - last good received counter value
//               o_valid     - one-cycle pulse when o_counter updates
//               o_frame_err - one-cycle pulse on a discarded frame
//               o_state     - FSM state (00 IDLE, 01 RX_HIGH, 10 RX_LOW,
//                             11 DRAIN)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_counter_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    spi_counter_rx_if.slave   spi,
    output logic [13:0]       o_counter,
    output logic              o_valid,
    output logic              o_frame_err,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RX_HIGH = 2'b01,
        ST_RX_LOW  = 2'b10,
        ST_DRAIN   = 2'b11
    } state_t;

    //--------------------------------------------------------------------------
    // Input synchronizers (shift in at bit 0, use the top bit)
    //--------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_ss_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   spi.ss};
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];

    //--------------------------------------------------------------------------
    // Edge detection. Edge strobes are registered so the FSM acts exactly
    // SYNC_STAGES+2 cycles after a raw pin transition; mosi is delayed by the
    // same amount so it lines up with the sclk rising strobe.
    //--------------------------------------------------------------------------
    logic r_sclk_d;
    logic r_ss_d;
    logic r_sclk_rise;
    logic r_sclk_fall;
    logic r_ss_rise;
    logic r_ss_fall;
    logic r_mosi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_mosi_q    <= 1'b0;
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
            r_sclk_rise <= w_sclk_s & ~r_sclk_d;
            r_sclk_fall <= ~w_sclk_s & r_sclk_d;
            r_ss_rise   <= w_ss_s & ~r_ss_d;
            r_ss_fall   <= ~w_ss_s & r_ss_d;
            r_mosi_q    <= w_mosi_s;
        end
    end

    //--------------------------------------------------------------------------
    // Receive FSM and datapath registers
    //--------------------------------------------------------------------------
    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_hi_byte;
    logic [15:0] r_tx;
    logic [13:0] r_counter;
    logic        r_valid;
    logic        r_frame_err;

    state_t      w_state_nxt;
    logic [2:0]  w_bit_cnt_nxt;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  w_hi_byte_nxt;
    logic [15:0] w_tx_nxt;
    logic [13:0] w_counter_nxt;
    logic        w_valid_nxt;
    logic        w_frame_err_nxt;
    logic [7:0]  w_shift_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_hi_byte   <= 8'd0;
            r_tx        <= 16'd0;
            r_counter   <= 14'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_hi_byte   <= w_hi_byte_nxt;
            r_tx        <= w_tx_nxt;
            r_counter   <= w_counter_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_hi_byte_nxt   = r_hi_byte;
        w_tx_nxt        = r_tx;
        w_counter_nxt   = r_counter;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_shift_in      = {r_shift[6:0], r_mosi_q};

        if (r_ss_rise) begin
            // Deselect ends any frame. In RX_LOW at least eight bits have
            // arrived, so that is always a partial frame; in RX_HIGH only a
            // non-zero bit count makes it one.
            if ((r_state == ST_RX_LOW) ||
                ((r_state == ST_RX_HIGH) && (r_bit_cnt != 3'd0))) begin
                w_frame_err_nxt = 1'b1;
            end
            w_state_nxt = ST_IDLE;
        end else if (r_ss_fall) begin
            w_state_nxt   = ST_RX_HIGH;
            w_bit_cnt_nxt = 3'd0;
            w_tx_nxt      = {2'b00, r_counter};
        end else begin
            // MISO shifts on every falling edge while selected; in DRAIN this
            // just empties the register.
            if (r_sclk_fall && (r_state != ST_IDLE)) begin
                w_tx_nxt = {r_tx[14:0], 1'b0};
            end

            unique case (r_state)
                ST_RX_HIGH: begin
                    if (r_sclk_rise) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_hi_byte_nxt = w_shift_in;
                            w_state_nxt   = ST_RX_LOW;
                        end
                    end
                end
                ST_RX_LOW: begin
                    if (r_sclk_rise) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_hi_byte[7:6] == 2'b00) begin
                                w_counter_nxt = {r_hi_byte[5:0], w_shift_in};
                                w_valid_nxt   = 1'b1;
                            end else begin
                                w_frame_err_nxt = 1'b1;
                            end
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                end
                default: begin
                    // IDLE and DRAIN ignore SCLK edges.
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. MISO is gated by the FSM state rather than the synchronized ss
    // so that a stale TX bit never shows between the ss fall and the TX load.
    //--------------------------------------------------------------------------
    assign spi.miso    = (r_state != ST_IDLE) ? r_tx[15] : 1'b0;
    assign o_counter   = r_counter;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_spi_counter_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_spi_counter_rx
// Description : Directed self-checking bench for spi_counter_rx. Drives SPI
//               mode-0 frames at 1 MHz SCLK (100 MHz clk) and checks decoded
//               values, pulse counts, latencies and the MISO echo.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_counter_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] o_counter;
    logic        o_valid;
    logic        o_frame_err;
    logic [1:0]  o_state;

    spi_counter_rx_if spi ();

    spi_counter_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (spi),
        .o_counter   (o_counter),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    int cyc         = 0;
    int valid_cnt   = 0;
    int err_cnt     = 0;
    int valid_cyc   = 0;
    int err_cyc     = 0;
    int rise_cyc    = 0;
    int ss_rise_cyc = 0;
    int n_pass      = 0;
    int n_checks    = 0;
    logic [15:0] rx_miso = '0;

    // Cycle counter and pulse monitor, sampled 1 ns after the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (o_valid) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (o_frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends the top nbits of data MSB-first; captures MISO just before each
    // rising edge. Optionally deselects and holds ss high for gap cycles.
    task automatic send(input logic [31:0] data, input int nbits, input int gap, input bit do_raise);
        @(negedge clk);
        spi.ss = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = data[nbits-1-i];
            repeat (50) @(negedge clk);
            rx_miso  = {rx_miso[14:0], spi.miso};
            spi.sclk = 1'b1;
            rise_cyc = cyc;
            repeat (50) @(negedge clk);
            spi.sclk = 1'b0;
        end
        spi.mosi = 1'b0;
        repeat (10) @(negedge clk);
        if (do_raise) begin
            spi.ss      = 1'b1;
            ss_rise_cyc = cyc;
            repeat (gap) @(negedge clk);
        end
    endtask

    int v0;
    int e0;
    logic [15:0] loop_vals [3] = '{16'h0000, 16'h0001, 16'h3FFF};
    logic [15:0] prev;

    initial begin
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.ss   = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_counter", {18'd0, o_counter}, 32'h0);
        check("rst_valid",   {31'd0, o_valid}, 32'h0);
        check("rst_err",     {31'd0, o_frame_err}, 32'h0);
        check("rst_miso",    {31'd0, spi.miso}, 32'h0);
        check("rst_state",   {30'd0, o_state}, 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Basic frame 0x13 / 0x39.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'h1339, 16, 30, 1'b1);
        check("f1_counter", {18'd0, o_counter}, 32'h1339);
        check("f1_valid_n", valid_cnt - v0, 1);
        check("f1_err_n",   err_cnt - e0, 0);
        check("f1_latency", valid_cyc - rise_cyc, 4);
        check("f1_miso",    {16'd0, rx_miso}, 32'h0000);
        prev = 16'h1339;

        // Loopback values; MISO echoes the previous value.
        for (int k = 0; k < 3; k++) begin
            v0 = valid_cnt;
            send({16'd0, loop_vals[k]}, 16, 30, 1'b1);
            check("lb_counter", {18'd0, o_counter}, {16'd0, loop_vals[k]});
            check("lb_valid_n", valid_cnt - v0, 1);
            check("lb_miso",    {16'd0, rx_miso}, {16'd0, prev});
            prev = loop_vals[k];
        end

        // Bad high byte 0xC1.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'hC100, 16, 30, 1'b1);
        check("bad_err_n",   err_cnt - e0, 1);
        check("bad_valid_n", valid_cnt - v0, 0);
        check("bad_counter", {18'd0, o_counter}, 32'h3FFF);
        check("bad_miso",    {16'd0, rx_miso}, 32'h3FFF);

        // Partial frame of 11 bits, then a full frame 0x0005.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'h1A5, 11, 30, 1'b1);
        check("part_err_n",   err_cnt - e0, 1);
        check("part_latency", err_cyc - ss_rise_cyc, 4);
        check("part_state",   {30'd0, o_state}, 32'h0);
        check("part_valid_n", valid_cnt - v0, 0);
        send(32'h0005, 16, 30, 1'b1);
        check("part_next",    {18'd0, o_counter}, 32'h5);

        // Three bytes in one window: third byte ignored.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'h002AFF, 24, 30, 1'b1);
        check("drain_counter", {18'd0, o_counter}, 32'h2A);
        check("drain_valid_n", valid_cnt - v0, 1);
        check("drain_err_n",   err_cnt - e0, 0);

        // Back-to-back frames with a one-cycle ss-high gap.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'h0ABC, 16, 0, 1'b1);
        send(32'h0123, 16, 30, 1'b1);
        check("b2b_counter", {18'd0, o_counter}, 32'h0123);
        check("b2b_valid_n", valid_cnt - v0, 2);
        check("b2b_err_n",   err_cnt - e0, 0);
        check("b2b_miso",    {16'd0, rx_miso}, 32'h0ABC);

        // Reset after 12 bits of 0x0102.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'h010, 12, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_counter", {18'd0, o_counter}, 32'h0);
        check("mrst_state",   {30'd0, o_state}, 32'h0);
        check("mrst_miso",    {31'd0, spi.miso}, 32'h0);
        spi.ss = 1'b1;
        repeat (30) @(negedge clk);
        check("mrst_valid_n", valid_cnt - v0, 0);
        check("mrst_err_n",   err_cnt - e0, 0);
        send(32'h0102, 16, 30, 1'b1);
        check("mrst_next",    {18'd0, o_counter}, 32'h0102);
        check("mrst_miso_nx", {16'd0, rx_miso}, 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_counter_rx.md
# spi_counter_rx

SPI slave receiver that sits directly downstream of the counter SPI master. It reassembles the two-byte frame (high byte `{2'b00, cnt[13:8]}`, then low byte `cnt[7:0]`, MSB-first, SPI mode 0) into a 14-bit counter value. It flags malformed frames and shifts the previously received value back on MISO. All SPI inputs are asynchronous to `clk` and are oversampled.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `mosi`, `ss` (≥2).
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `sclk` input 1: SPI clock from master, idle low.
- `mosi` input 1: SPI data from master.
- `ss` input 1: slave select, active low.
- `miso` output 1: SPI data to master.
- `o_counter` output 14: last good received counter value.
- `o_valid` output 1: one-cycle pulse when `o_counter` updates.
- `o_frame_err` output 1: one-cycle pulse on a discarded frame.
- `o_state` output 2: FSM state, for debug (00 IDLE, 01 RX_HIGH, 10 RX_LOW, 11 DRAIN).

## Operation
- Each of `sclk`, `mosi`, `ss` passes through `SYNC_STAGES` flops. A further flop on `sclk` and `ss` supplies edge detection. All logic uses only the synchronized versions.
- SPI mode 0:
  - Sample `mosi` on synchronized SCLK rising edge.
  - Shift `miso` on synchronized SCLK falling edge.
  - Shifts are MSB-first into an 8-bit shift register with a 3-bit bit counter.
- FSM:
  - IDLE: `ss` high. On SS falling edge → RX_HIGH; clear bit counter; load 16-bit TX register with `{2'b00, o_counter}`.
  - RX_HIGH: after 8th rising edge, latch shift register into `hi_byte` → RX_LOW.
  - RX_LOW: after 8th rising edge, check `hi_byte[7:6]`:
    - If `2'b00`: `o_counter <= {hi_byte[5:0], byte}`, pulse `o_valid`.
    - Otherwise: pulse `o_frame_err` and leave `o_counter` unchanged.
    - Either way → DRAIN.
  - DRAIN: ignore further SCLK edges (extra bytes are discarded without error).
  - SS rising edge in any state → IDLE.
- SS rising edge in RX_HIGH/RX_LOW with at least one bit received in the frame (partial frame): pulse `o_frame_err`, discard. SS toggle with zero bits received: no error.
- MISO: while `ss` is low, `miso` = TX register MSB. TX shifts left one bit per falling edge. The first bit is valid before the first rising edge. While `ss` is high, `miso` = 0.
- Transitions with `ss` high are ignored; SCLK edges in IDLE are ignored.

## Timing
- Reset values:
  - `o_counter` = 0, `o_valid` = 0, `o_frame_err` = 0, `miso` = 0, `o_state` = IDLE.
  - Synchronizers, shift register, and counters cleared.
- Reset asserted mid-frame aborts the frame with no error pulse. The next frame begins at the next SS falling edge after reset release.
- Latency: `o_valid`/`o_counter` update exactly `SYNC_STAGES+2` clk cycles after the raw SCLK rising edge of bit 16 (4 cycles at default).
- `o_frame_err` for a partial frame: `SYNC_STAGES+2` cycles after the raw SS rising edge.
- `o_valid` and `o_frame_err` are mutually exclusive and each is high for exactly 1 cycle.
- Constraint on master: SCLK high and low phases ≥ `SYNC_STAGES+2` clk cycles. SS setup before first SCLK rise ≥ `SYNC_STAGES+2` cycles.
- `miso` changes no later than `SYNC_STAGES+2` cycles after a raw SCLK falling edge (or SS falling edge for the first bit).
- Back-to-back frames with a 1-cycle synchronized SS-high gap are received correctly.

## Test plan
- Reset, then frame 0x13 / 0x39 in one SS window at SCLK = 1 MHz → `o_counter` = 0x1339 (4921), single `o_valid` pulse 4 cycles after the 16th rising edge, no error.
- Loopback of the upstream master's frames at counter values 0, 1, 0x3FFF → `o_counter` tracks each value, one `o_valid` per frame. Following frame's `miso` stream = `{2'b00, previous value}` (e.g. 0x3FFF).
- High byte 0xC1, low byte 0x00 → `o_frame_err` pulse, `o_counter` unchanged, `o_valid` stays 0.
- SS raised after 11 bits → `o_frame_err` pulse 4 cycles after SS rise, state IDLE. Next full frame 0x00/0x05 → `o_counter` = 5.
- Three bytes 0x00/0x2A/0xFF in one SS window → `o_counter` = 0x002A, third byte ignored, no error.
- `reset` pulsed after 12 bits of frame 0x01/0x02 → all outputs 0, no pulse. Subsequent frame 0x01/0x02 → `o_counter` = 0x0102.
